// File: rtl/pipeline_sequencer_if.sv
// Bundle between the ID-stage hazard sequencer and the pipeline registers:
// decoded operand fields and EX/MEM destination info in, register enables out.
interface pipeline_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [1:0]       id_compare_code;
  logic             id_branch_taken;
  logic             id_is_jr;
  logic [4:0]       ex_dest;
  logic [4:0]       mem_dest;
  logic             ex_reg_write;
  logic             mem_reg_write;
  logic             ex_mem_read;
  logic             mem_mem_read;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_compare_code, id_branch_taken, id_is_jr,
           ex_dest, mem_dest, ex_reg_write, mem_reg_write, ex_mem_read, mem_mem_read,
           mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble,
           memwb_bubble, halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_compare_code, id_branch_taken, id_is_jr,
           ex_dest, mem_dest, ex_reg_write, mem_reg_write, ex_mem_read, mem_mem_read,
           mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble,
           memwb_bubble, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Hazard/stall sequencer for the 5-stage mips32 pipeline: load-use and branch
// operand stalls, taken-transfer flush, and a data-memory wait FSM with timeout halt.
module pipeline_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_sequencer_if.slave bus
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [15:0]      wait_cnt, wait_nxt;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q;

  logic is_branch, rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, br_ex, br_mem, hz, taken;
  logic pc_en, ifid_en, idex_en, exmem_en, flush, idex_bub, memwb_bub;

  assign is_branch = (bus.id_compare_code == 2'b01) || (bus.id_compare_code == 2'b10) ||
                     bus.id_is_jr;
  assign rs_ex  = (bus.ex_dest  != 5'd0) && (bus.ex_dest  == bus.id_rs);
  assign rt_ex  = (bus.ex_dest  != 5'd0) && (bus.ex_dest  == bus.id_rt) && bus.id_uses_rt;
  assign rs_mem = (bus.mem_dest != 5'd0) && (bus.mem_dest == bus.id_rs);
  assign rt_mem = (bus.mem_dest != 5'd0) && (bus.mem_dest == bus.id_rt) && bus.id_uses_rt;

  assign load_use = bus.ex_mem_read && (rs_ex || rt_ex);
  assign br_ex    = is_branch && bus.ex_reg_write && (rs_ex || rt_ex);
  assign br_mem   = is_branch && bus.mem_mem_read && (rs_mem || rt_mem);
  assign hz       = load_use || br_ex || br_mem;
  assign taken    = (bus.id_compare_code == 2'b11) ||
                    ((bus.id_compare_code != 2'b00) && bus.id_branch_taken);

  // Reset forces the pass-through control word so no stale bubble leaks out.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    flush     = 1'b0;
    idex_bub  = 1'b0;
    memwb_bub = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!reset) begin
      if (state == HALT) begin
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
        memwb_bub = 1'b1;
      end else if (!bus.mem_ready && (state == MEM_WAIT || bus.mem_req)) begin
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
        memwb_bub = 1'b1;
        if (state == RUN) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 16'd1;
        end else if (wait_cnt == 16'(MEM_TIMEOUT)) begin
          state_nxt = HALT;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end else begin
        state_nxt = RUN;
        wait_nxt  = '0;
        if (hz) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_bub = 1'b1;
        end else if (taken) begin
          flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      halted_q <= (state_nxt == HALT);
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pc_write     = pc_en;
  assign bus.ifid_write   = ifid_en;
  assign bus.idex_write   = idex_en;
  assign bus.exmem_write  = exmem_en;
  assign bus.ifid_flush   = flush;
  assign bus.idex_bubble  = idex_bub;
  assign bus.memwb_bubble = memwb_bub;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: vector table, multi-cycle corner sequences and
// randomized traffic checked against a behavioural model of the hazard rules.
module tb_pipeline_sequencer;
  localparam int unsigned TMO  = 4;
  localparam int unsigned CW   = 6;
  localparam int unsigned MAXS = (1 << CW) - 1;

  localparam logic [6:0] NORMAL = 7'b1111_000;
  localparam logic [6:0] HZ     = 7'b0011_010;
  localparam logic [6:0] FLUSH  = 7'b1111_100;
  localparam logic [6:0] FREEZE = 7'b0000_001;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [1:0] code;
    logic       taken, jr;
    logic [4:0] ex_dest, mem_dest;
    logic       ex_rw, mem_rw, ex_mr, mem_mr, req, ready;
  } in_t;

  typedef struct packed {
    in_t        v;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  pipeline_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  in_t         cur;
  bit          cur_rst;
  bit          m_halted;
  int unsigned m_wait_len;
  int unsigned m_stall;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  task automatic apply(input in_t v, input bit r);
    cur = v;
    cur_rst = r;
    reset = r;
    bus.id_rs = v.rs;             bus.id_rt = v.rt;
    bus.id_uses_rt = v.uses_rt;   bus.id_compare_code = v.code;
    bus.id_branch_taken = v.taken; bus.id_is_jr = v.jr;
    bus.ex_dest = v.ex_dest;      bus.mem_dest = v.mem_dest;
    bus.ex_reg_write = v.ex_rw;   bus.mem_reg_write = v.mem_rw;
    bus.ex_mem_read = v.ex_mr;    bus.mem_mem_read = v.mem_mr;
    bus.mem_req = v.req;          bus.mem_ready = v.ready;
  endtask

  function automatic logic [6:0] ctrl_now();
    return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
            bus.ifid_flush, bus.idex_bubble, bus.memwb_bubble};
  endfunction

  // Expected control word from the hazard rules applied to the operand list.
  function automatic logic [6:0] model_ctrl(input in_t v, input bit r);
    logic [4:0] srcs[$];
    bit branch, lu, bx, bm;
    if (r) return NORMAL;
    if (m_halted) return FREEZE;
    if (!v.ready && (m_wait_len > 0 || v.req)) return FREEZE;
    branch = (v.code == 2'b01) || (v.code == 2'b10) || v.jr;
    lu = 0; bx = 0; bm = 0;
    srcs.push_back(v.rs);
    if (v.uses_rt) srcs.push_back(v.rt);
    foreach (srcs[i]) begin
      if (srcs[i] != 5'd0) begin
        if (v.ex_mr && v.ex_dest == srcs[i]) lu = 1;
        if (branch && v.ex_rw && v.ex_dest == srcs[i]) bx = 1;
        if (branch && v.mem_mr && v.mem_dest == srcs[i]) bm = 1;
      end
    end
    if (lu || bx || bm) return HZ;
    if (v.code == 2'b11 || (v.code != 2'b00 && v.taken)) return FLUSH;
    return NORMAL;
  endfunction

  task automatic model_update(input logic [6:0] exp);
    if (cur_rst) begin
      m_halted = 0; m_wait_len = 0; m_stall = 0;
    end else begin
      if (!exp[6]) m_stall = (m_stall == MAXS) ? MAXS : m_stall + 1;
      if (!m_halted) begin
        if (!cur.ready && (m_wait_len > 0 || cur.req)) begin
          m_wait_len++;
          if (m_wait_len > TMO) m_halted = 1;
        end else begin
          m_wait_len = 0;
        end
      end
    end
  endtask

  task automatic check_cycle(input string name);
    logic [6:0] exp;
    @(negedge clk);
    exp = model_ctrl(cur, cur_rst);
    check({name, "_ctrl"}, 32'(ctrl_now()), 32'(exp));
    check({name, "_halted"}, 32'(bus.halted), 32'(m_halted));
    check({name, "_stall"}, 32'(bus.stall_cycles), m_stall);
    @(posedge clk);
    model_update(exp);
    #1;
  endtask

  task automatic do_reset();
    apply(idle(), 1);
    repeat (2) @(posedge clk);
    #1;
    m_halted = 0; m_wait_len = 0; m_stall = 0;
    apply(idle(), 0);
  endtask

  vec_t tbl[16];

  initial begin
    in_t v;
    int unsigned s0;

    // rs, rt, uses_rt, code, taken, jr, ex_dest, mem_dest, ex_rw, mem_rw, ex_mr, mem_mr, req, ready
    tbl[0]  = '{'{5'd8, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, HZ};
    tbl[1]  = '{'{5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, NORMAL};
    tbl[2]  = '{'{5'd3, 5'd8, 1'b0, 2'b00, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, NORMAL};
    tbl[3]  = '{'{5'd3, 5'd8, 1'b1, 2'b00, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, HZ};
    tbl[4]  = '{'{5'd3, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, FLUSH};
    tbl[5]  = '{'{5'd3, 5'd4, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, NORMAL};
    tbl[6]  = '{'{5'd0, 5'd0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, FLUSH};
    tbl[7]  = '{'{5'd9, 5'd10, 1'b1, 2'b10, 1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, HZ};
    tbl[8]  = '{'{5'd4, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, HZ};
    tbl[9]  = '{'{5'd4, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, FLUSH};
    tbl[10] = '{'{5'd31, 5'd0, 1'b0, 2'b11, 1'b0, 1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, HZ};
    tbl[11] = '{'{5'd9, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, NORMAL};
    tbl[12] = '{'{5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}, NORMAL};
    tbl[13] = '{'{5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, NORMAL};
    tbl[14] = '{'{5'd5, 5'd0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, FLUSH};
    tbl[15] = '{'{5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, NORMAL};

    do_reset();
    @(negedge clk);
    check("reset_ctrl", 32'(ctrl_now()), 32'(NORMAL));
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_stall", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk); #1;

    // Single-cycle vectors, each starting from RUN with no pending access.
    foreach (tbl[i]) begin
      apply(tbl[i].v, 0);
      #1;
      check($sformatf("vec%0d", i), 32'(ctrl_now()), 32'(tbl[i].exp));
      check_cycle($sformatf("vec%0d_model", i));
    end
    apply(idle(), 0);
    check_cycle("idle");

    // Load-use then single-cycle stall count.
    do_reset();
    v = idle(); v.rs = 5'd8; v.ex_dest = 5'd8; v.ex_mr = 1; v.ex_rw = 1;
    apply(v, 0); check_cycle("lu");
    apply(idle(), 0); check_cycle("lu_after");
    check("lu_stall_count", 32'(bus.stall_cycles), 32'd1);

    // BNE on a load result: load_use, then br_mem, then the taken branch flushes.
    v = idle(); v.rs = 5'd9; v.code = 2'b10; v.taken = 1; v.ex_dest = 5'd9; v.ex_mr = 1; v.ex_rw = 1;
    apply(v, 0); check_cycle("bne_b1");
    check("bne_b1_flush", 32'(bus.ifid_flush), 32'd0);
    v.ex_dest = 5'd0; v.ex_mr = 0; v.ex_rw = 0; v.mem_dest = 5'd9; v.mem_mr = 1; v.mem_rw = 1;
    apply(v, 0); #1;
    check("bne_b2_bubble", 32'(bus.idex_bubble), 32'd1);
    check_cycle("bne_b2");
    v.mem_dest = 5'd0; v.mem_mr = 0; v.mem_rw = 0;
    apply(v, 0); #1;
    check("bne_resolve_flush", 32'(bus.ifid_flush), 32'd1);
    check_cycle("bne_resolve");

    // Three wait cycles then completion.
    s0 = m_stall;
    v = idle(); v.req = 1; v.ready = 0;
    for (int i = 0; i < 3; i++) begin
      apply(v, 0); #1;
      check($sformatf("wait%0d_ctrl", i), 32'(ctrl_now()), 32'(FREEZE));
      check_cycle($sformatf("wait%0d", i));
    end
    v.ready = 1;
    apply(v, 0); check_cycle("wait_done");
    check("wait_stall_delta", 32'(bus.stall_cycles), s0 + 3);

    // Reset during the second wait cycle.
    v = idle(); v.req = 1; v.ready = 0;
    apply(v, 0); check_cycle("rwait1");
    apply(v, 1); #1;
    check("rwait_reset_ctrl", 32'(ctrl_now()), 32'(NORMAL));
    check_cycle("rwait_reset");
    apply(idle(), 0); #1;
    check("rwait_after_ctrl", 32'(ctrl_now()), 32'(NORMAL));
    check("rwait_after_stall", 32'(bus.stall_cycles), 32'd0);
    check_cycle("rwait_after");

    // Timeout: halted only after TMO cycles in MEM_WAIT, then sticky.
    v = idle(); v.req = 1; v.ready = 0;
    for (int i = 0; i < 4; i++) begin apply(v, 0); check_cycle("tmo_pre"); end
    check("tmo_not_yet", 32'(bus.halted), 32'd0);
    apply(v, 0); check_cycle("tmo_last");
    check("tmo_halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 100; i++) begin
      v = in_t'($urandom);
      v.ready = 1;
      apply(v, 0); check_cycle("halt_hold");
    end
    check("halt_sticky", 32'(bus.halted), 32'd1);
    check("stall_saturated", 32'(bus.stall_cycles), MAXS);

    // Randomized traffic with small register numbers to force collisions.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v.rs = 5'($urandom_range(0, 5));   v.rt = 5'($urandom_range(0, 5));
      v.uses_rt = 1'($urandom);          v.code = 2'($urandom);
      v.taken = 1'($urandom);            v.jr = ($urandom_range(0, 7) == 0);
      v.ex_dest = 5'($urandom_range(0, 5)); v.mem_dest = 5'($urandom_range(0, 5));
      v.ex_rw = 1'($urandom);  v.mem_rw = 1'($urandom);
      v.ex_mr = 1'($urandom);  v.mem_mr = 1'($urandom);
      v.req = 1'($urandom);    v.ready = ($urandom_range(0, 2) != 0);
      apply(v, ($urandom_range(0, 79) == 0));
      check_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
